fifo_param: RTL and testbench

Parametrised synchronous FIFO, the successor to the fixed 32×16 flop FIFO. Width, depth and almost-full/almost-empty thresholds are configurable. Adds an occupancy count, sticky overflow/underflow error flags, and optional first-word-fall-through output. It sits between a producer using push/Din and a consumer using pop/Dout/pndng in the same clock domain.

---
 rtl/fifo_param.sv | 100 ++++++++++
 tb/tb_fifo_param.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, thresholds and sticky error flags.
// Define FIFO_FWFT_EN for first-word-fall-through output; default is registered-read Dout.
module fifo_param #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int AF_LVL = 14,
    parameter int AE_LVL = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           Din,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           Dout,
    output logic                       full,
    output logic                       pndng,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d, unf_q, unf_d;
    logic             push_ok, pop_ok;

    // Explicit wrap so non-power-of-two depths never address past the last entry
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != CW'(DEPTH)) || pop_ok);
        wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        // A new error in the same cycle as clr_err leaves the flag set
        ovf_d = (ovf_q && !clr_err) || (push && !push_ok);
        unf_d = (unf_q && !clr_err) || (pop && (count_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage is not reset; only the pointers define validity
    always_ff @(posedge clk) begin
        if (!rst && push_ok)
            mem_q[wr_ptr_q] <= Din;
    end

`ifdef FIFO_FWFT_EN
    assign Dout = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
`else
    logic [WIDTH-1:0] dout_q, dout_d;

    always_comb begin
        dout_d = pop_ok ? mem_q[rd_ptr_q] : dout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else     dout_q <= dout_d;
    end

    assign Dout = dout_q;
`endif

    assign count        = count_q;
    assign full         = (count_q == CW'(DEPTH));
    assign pndng        = (count_q != '0);
    assign almost_full  = (count_q >= CW'(AF_LVL));
    assign almost_empty = (count_q <= CW'(AE_LVL));
    assign overflow     = ovf_q;
    assign underflow    = unf_q;
endmodule

// File: tb/tb_fifo_param.sv
// Directed bench for fifo_param: default 32x16 instance plus a DEPTH=5 instance for wrap/reset.
module tb_fifo_param;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // default instance
    logic        rst, push, pop, clr_err;
    logic [31:0] din, dout;
    logic [4:0]  count;
    logic        full, pndng, af, ae, ovf, unf;

    fifo_param dut_a (
        .clk(clk), .rst(rst), .Din(din), .push(push), .pop(pop), .clr_err(clr_err),
        .Dout(dout), .full(full), .pndng(pndng), .count(count),
        .almost_full(af), .almost_empty(ae), .overflow(ovf), .underflow(unf)
    );

    // non-power-of-two instance
    logic        b_rst, b_push, b_pop, b_clr;
    logic [7:0]  b_din, b_dout;
    logic [2:0]  b_count;
    logic        b_full, b_pndng, b_af, b_ae, b_ovf, b_unf;

    fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LVL(4), .AE_LVL(1)) dut_b (
        .clk(clk), .rst(b_rst), .Din(b_din), .push(b_push), .pop(b_pop), .clr_err(b_clr),
        .Dout(b_dout), .full(b_full), .pndng(b_pndng), .count(b_count),
        .almost_full(b_af), .almost_empty(b_ae), .overflow(b_ovf), .underflow(b_unf)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        push, pop, clr;
        logic [31:0] din;
        logic [4:0]  cnt;
        logic [31:0] dout;
        logic        pndng, unf;
    } vec_t;

    vec_t        vt[11];
    logic [31:0] mq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, want);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic b_do(input string nm, input logic ps, input logic pp, input logic [7:0] d,
                        input int want_cnt, input logic [7:0] want_dout);
        b_push = ps; b_pop = pp; b_din = d;
        tick();
        b_push = 1'b0; b_pop = 1'b0;
        chk({nm, " cnt"}, 32'(b_count), 32'(want_cnt));
        chk({nm, " dout"}, 32'(b_dout), 32'(want_dout));
    endtask

    initial begin
        logic [31:0] want;
        rst = 1'b1; push = 1'b1; pop = 1'b0; clr_err = 1'b0; din = 32'hA5;
        b_rst = 1'b1; b_push = 1'b0; b_pop = 1'b0; b_clr = 1'b0; b_din = '0;

        // reset with push held high must not write
        tick(); tick();
        chk("rst count", 32'(count), 0);
        chk("rst pndng", 32'(pndng), 0);
        chk("rst full", 32'(full), 0);
        chk("rst ae", 32'(ae), 1);
        chk("rst af", 32'(af), 0);
        chk("rst dout", dout, 0);
        chk("rst flags", {30'd0, ovf, unf}, 0);
        rst = 1'b0; push = 1'b0;
        tick();
        chk("post-rst count", 32'(count), 0);

        //         push pop clr din    cnt dout  pndng unf
        vt[0]  = '{1, 1, 0, 32'd7,  1, 32'd0,  1, 1};   // pop on empty, push still accepted
        vt[1]  = '{0, 0, 1, 32'd0,  1, 32'd0,  1, 0};
        vt[2]  = '{0, 1, 0, 32'd0,  0, 32'd7,  0, 0};
        vt[3]  = '{1, 0, 0, 32'd11, 1, 32'd7,  1, 0};
        vt[4]  = '{1, 0, 0, 32'd22, 2, 32'd7,  1, 0};
        vt[5]  = '{1, 1, 0, 32'd33, 2, 32'd11, 1, 0};
        vt[6]  = '{0, 1, 0, 32'd0,  1, 32'd22, 1, 0};
        vt[7]  = '{0, 1, 0, 32'd0,  0, 32'd33, 0, 0};
        vt[8]  = '{0, 1, 0, 32'd0,  0, 32'd33, 0, 1};
        vt[9]  = '{0, 1, 1, 32'd0,  0, 32'd33, 0, 1};   // set wins over clear
        vt[10] = '{0, 0, 1, 32'd0,  0, 32'd33, 0, 0};
        for (int i = 0; i < 11; i++) begin
            push = vt[i].push; pop = vt[i].pop; clr_err = vt[i].clr; din = vt[i].din;
            tick();
            chk($sformatf("vec%0d cnt", i), 32'(count), 32'(vt[i].cnt));
            chk($sformatf("vec%0d dout", i), dout, vt[i].dout);
            chk($sformatf("vec%0d pndng", i), 32'(pndng), 32'(vt[i].pndng));
            chk($sformatf("vec%0d unf", i), 32'(unf), 32'(vt[i].unf));
            chk($sformatf("vec%0d ovf", i), 32'(ovf), 0);
        end
        push = 1'b0; pop = 1'b0; clr_err = 1'b0;

        // fill 0..15
        for (int i = 0; i < 16; i++) begin
            push = 1'b1; din = 32'(i);
            tick();
            mq.push_back(32'(i));
            chk($sformatf("fill%0d cnt", i), 32'(count), 32'(i + 1));
            chk($sformatf("fill%0d af", i), 32'(af), 32'(i + 1 >= 14));
            chk($sformatf("fill%0d full", i), 32'(full), 32'(i + 1 == 16));
        end

        // overflow: dropped word must never appear
        din = 32'hDEAD;
        tick();
        push = 1'b0;
        chk("ovf cnt", 32'(count), 16);
        chk("ovf flag", 32'(ovf), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr ovf", 32'(ovf), 0);
        chk("clr cnt", 32'(count), 16);

        // push+pop at full across pointer wrap
        for (int k = 0; k < 20; k++) begin
            push = 1'b1; pop = 1'b1; din = 32'(100 + k);
            tick();
            want = mq.pop_front();
            mq.push_back(32'(100 + k));
            chk($sformatf("simul%0d dout", k), dout, want);
            chk($sformatf("simul%0d cnt", k), 32'(count), 16);
            chk($sformatf("simul%0d ovf", k), 32'(ovf), 0);
        end
        push = 1'b0;

        // drain
        for (int j = 0; j < 16; j++) begin
            pop = 1'b1;
            tick();
            want = mq.pop_front();
            chk($sformatf("drain%0d dout", j), dout, want);
            chk($sformatf("drain%0d cnt", j), 32'(count), 32'(15 - j));
            chk($sformatf("drain%0d ae", j), 32'(ae), 32'(15 - j <= 2));
            chk($sformatf("drain%0d pndng", j), 32'(pndng), 32'(15 - j != 0));
        end
        pop = 1'b0;
        tick();
        chk("drained unf", 32'(unf), 0);

        // DEPTH=5 instance: wrap and mid-stream reset
        b_rst = 1'b0;
        b_do("b push10", 1, 0, 8'h10, 1, 8'h00);
        b_do("b push11", 1, 0, 8'h11, 2, 8'h00);
        b_do("b push12", 1, 0, 8'h12, 3, 8'h00);
        b_do("b push13", 1, 0, 8'h13, 4, 8'h00);
        chk("b af at 4", 32'(b_af), 1);
        chk("b full at 4", 32'(b_full), 0);
        b_do("b push14", 1, 0, 8'h14, 5, 8'h00);
        chk("b full at 5", 32'(b_full), 1);
        b_do("b pop1", 0, 1, 8'h00, 4, 8'h10);
        b_do("b pop2", 0, 1, 8'h00, 3, 8'h11);
        b_do("b pop3", 0, 1, 8'h00, 2, 8'h12);
        b_do("b push15", 1, 0, 8'h15, 3, 8'h12);
        b_do("b push16", 1, 0, 8'h16, 4, 8'h12);
        b_do("b pop4", 0, 1, 8'h00, 3, 8'h13);
        b_do("b pop5", 0, 1, 8'h00, 2, 8'h14);
        chk("b ae at 2", 32'(b_ae), 0);
        b_do("b pop6", 0, 1, 8'h00, 1, 8'h15);
        chk("b ae at 1", 32'(b_ae), 1);
        b_do("b push17", 1, 0, 8'h17, 2, 8'h15);
        chk("b ovf none", 32'(b_ovf), 0);

        b_rst = 1'b1; b_push = 1'b1; b_pop = 1'b1; b_din = 8'hEE;
        tick();
        b_rst = 1'b0; b_push = 1'b0; b_pop = 1'b0;
        chk("b rst cnt", 32'(b_count), 0);
        chk("b rst dout", 32'(b_dout), 0);
        chk("b rst pndng", 32'(b_pndng), 0);
        chk("b rst ae", 32'(b_ae), 1);
        b_do("b push5A", 1, 0, 8'h5A, 1, 8'h00);
        b_do("b pop5A", 0, 1, 8'h00, 0, 8'h5A);
        chk("b final unf", 32'(b_unf), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
